my_bus_slave: RTL and testbench
===============================

Name: my_bus_slave

Overview:
- Bus target that consumes the myBus transaction stream (mode/addr/data/sel) produced by the testbench driver.
- Decodes single and incrementing-burst read/write commands into a local byte register window.
- Returns read data on a dedicated rdata/rvalid channel and flags protocol errors.
- The driver launches on negedge clk; this block samples on posedge clk.

Parameters:
- BASE_ADDR, 8'h00: first bus address owned by this slave.
- DEPTH, 16: number of byte registers. Power of 2, 2..256; BASE_ADDR must be DEPTH-aligned.
- RST_VAL, 8'h00: reset value of every register.

Ports:
- clk  input  1  bus clock, all state on posedge.
- rst  input  1  reset, asynchronous, active-low. Assertion clears all state immediately; deassertion is sampled by clk.
- mode  input  3  command code, see package.
- addr  input  8  byte address; meaningful on first beat only.
- data  input  8  write data, or beat count for READ_INC.
- sel  input  1  command valid qualifier; mode/addr/data are ignored when sel=0.
- rdata  output  8  read data.
- rvalid  output  1  rdata valid, one pulse per beat.
- busy  output  1  read burst in progress.
- err  output  1  one-cycle error pulse.

Behaviour:
- Reset values: rdata=8'h00, rvalid=0, busy=0, err=0, state=IDLE, all registers=RST_VAL, burst pointer=0, remaining count=0.
- Hit: a command hits when addr[7:log2(DEPTH)] == BASE_ADDR[7:log2(DEPTH)]; offset = addr[log2(DEPTH)-1:0].
- Modes:
  - 000 NOP: no action. No err, even with sel=1.
  - 001 WRITE: reg[offset] <= data at the sampling edge.
  - 010 READ: rdata=reg[offset] and rvalid=1 on the next cycle (latency 1).
  - 011 WRITE_INC: IDLE->WR_BURST. The first beat writes data at offset and sets ptr=offset+1.
  - 100 READ_INC: data = beat count N (1..255). IDLE->RD_BURST with ptr=offset, cnt=N.
  - 101/110/111: reserved.
- WR_BURST:
  - Each cycle with sel=1 and mode=011: writes data at ptr, then ptr <= ptr+1 mod DEPTH (wraps inside the window). addr is ignored.
  - sel=0 -> IDLE.
  - sel=1 with any other mode -> leaves burst; that cycle is decoded as a fresh command from IDLE.
- RD_BURST:
  - Each cycle: rdata=reg[ptr], rvalid=1, ptr++ mod DEPTH, cnt--.
  - busy=1 from the cycle after the command through the last beat.
  - Returns to IDLE after beat N. The first beat appears the cycle after the command.
  - Data reflects register contents at the cycle each beat is read.
- Error conditions: err pulses high the cycle after the offending command, and the command has no side effects.
  - Miss on WRITE/READ/WRITE_INC/READ_INC first beat.
  - Reserved mode.
  - READ_INC with N=0.
  - Any sel=1 non-NOP command while busy=1. The burst continues unaffected.
- Ordering:
  - Write then read of the same address in consecutive cycles returns the new data.
  - Writes and reads never occur in the same cycle, since there is one command per cycle.
- Reset mid-burst: immediate abort. Outputs and registers return to reset values; no further beats.
- rvalid is 0 whenever no beat is produced; rdata holds its last value.

Decomposition:
- Package my_bus_pkg:
  - mode_e enum (NOP, WRITE, READ, WRITE_INC, READ_INC).
  - state_e enum (IDLE, WR_BURST, RD_BURST).
  - Widths: MODE_W=3, ADDR_W=8, DATA_W=8.
- Sub-module my_bus_regfile:
  - DEPTH x 8 flop array, async active-low reset to RST_VAL.
  - One write port (we, waddr, wdata) and one combinational read port.
- Top-level my_bus_slave holds the decode logic, FSM, burst pointer/counter and output registers.

Test Plan (DEPTH=16, BASE_ADDR=8'h20):
- Reset then READ addr 8'h25 -> next cycle rvalid=1, rdata=8'h00, err=0.
- WRITE 8'h23<=8'hA5, then READ 8'h23 on the next cycle -> rvalid pulse with rdata=8'hA5 one cycle after the READ.
- WRITE_INC at 8'h2E with beats 11,22,33,44 -> regs 0xE=11, 0xF=22, 0x0=33, 0x1=44 (wrap). A following READ_INC 8'h2E, N=4 -> four consecutive rvalid beats 11,22,33,44; busy high for exactly 4 cycles.
- Error cases: WRITE 8'h40, mode 3'b110, and READ_INC with N=0 -> each gives an err pulse one cycle later, no register change, no rvalid.
- READ_INC N=8, then issue WRITE on beat 3 -> err pulse; burst completes all 8 beats; written address is unchanged.
- Assert rst low mid-read-burst (beat 2 of 6) -> rvalid/busy drop immediately, registers=RST_VAL; after release, READ returns 8'h00.

Source files
------------

// File: rtl/my_bus_pkg.sv
// Shared command/state encodings and bus widths for the myBus slave.
package my_bus_pkg;

  localparam int unsigned MODE_W = 3;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [MODE_W-1:0] {
    NOP       = 3'b000,
    WRITE     = 3'b001,
    READ      = 3'b010,
    WRITE_INC = 3'b011,
    READ_INC  = 3'b100
  } mode_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_BURST = 2'd2
  } state_e;

endpackage

// File: rtl/my_bus_regfile.sv
// Byte register window: one synchronous write port, one combinational read port.
module my_bus_regfile
  import my_bus_pkg::*;
#(
  parameter int unsigned       DEPTH   = 16,
  parameter int unsigned       AW      = 4,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= RST_VAL;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/my_bus_slave.sv
// myBus target: decodes single/burst commands into a byte register window,
// returns read beats on rdata/rvalid and pulses err on protocol violations.
module my_bus_slave
  import my_bus_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 8'h00,
  parameter int unsigned       DEPTH     = 16,
  parameter logic [DATA_W-1:0] RST_VAL   = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [MODE_W-1:0] mode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              sel,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              busy,
  output logic              err
);

  localparam int unsigned       AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] HIT_MASK = ADDR_W'(~(DEPTH - 1));

  state_e            state;
  logic [AW-1:0]     ptr;
  logic [DATA_W-1:0] cnt;

  mode_e             cmd;
  logic              hit, cont_wr, blocked, fresh;
  logic [AW-1:0]     off;
  logic              we;
  logic [AW-1:0]     waddr, raddr;
  logic [DATA_W-1:0] rd;

  assign cmd = mode_e'(mode);

  // busy covers the cycle after the last beat too, so a command landing there
  // is still rejected even though the FSM has already returned to IDLE.
  always_comb begin
    hit     = ((addr ^ BASE_ADDR) & HIT_MASK) == '0;
    off     = addr[AW-1:0];
    cont_wr = sel && (state == WR_BURST) && (cmd == WRITE_INC);
    blocked = sel && busy && (cmd != NOP);
    fresh   = sel && !busy && !cont_wr;
    we      = 1'b0;
    waddr   = off;
    raddr   = (state == RD_BURST) ? ptr : off;
    if (cont_wr) begin
      we    = 1'b1;
      waddr = ptr;
    end else if (fresh && hit && (cmd == WRITE || cmd == WRITE_INC)) begin
      we = 1'b1;
    end
  end

  my_bus_regfile #(
    .DEPTH  (DEPTH),
    .AW     (AW),
    .RST_VAL(RST_VAL)
  ) u_regfile (
    .clk  (clk),
    .rst  (rst),
    .we   (we),
    .waddr(waddr),
    .wdata(data),
    .raddr(raddr),
    .rdata(rd)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      ptr    <= '0;
      cnt    <= '0;
      rdata  <= '0;
      rvalid <= 1'b0;
      busy   <= 1'b0;
      err    <= 1'b0;
    end else begin
      rvalid <= 1'b0;
      busy   <= 1'b0;
      err    <= 1'b0;

      case (state)
        RD_BURST: begin
          rdata  <= rd;
          rvalid <= 1'b1;
          busy   <= 1'b1;
          ptr    <= ptr + 1'b1;
          cnt    <= cnt - 8'd1;
          if (cnt == 8'd1) state <= IDLE;
        end
        WR_BURST: begin
          if (cont_wr) ptr <= ptr + 1'b1;
          else state <= IDLE;
        end
        default: ;
      endcase

      // A non-burst command inside WR_BURST falls through to this fresh decode.
      if (blocked) begin
        err <= 1'b1;
      end else if (fresh) begin
        case (cmd)
          NOP: ;
          WRITE: if (!hit) err <= 1'b1;
          READ: begin
            if (hit) begin
              rdata  <= rd;
              rvalid <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
          WRITE_INC: begin
            if (hit) begin
              state <= WR_BURST;
              ptr   <= off + 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
          READ_INC: begin
            if (hit && data != '0) begin
              rdata  <= rd;
              rvalid <= 1'b1;
              busy   <= 1'b1;
              ptr    <= off + 1'b1;
              cnt    <= data - 8'd1;
              state  <= (data == 8'd1) ? IDLE : RD_BURST;
            end else begin
              err <= 1'b1;
            end
          end
          default: err <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_my_bus_slave.sv
// Randomized bench for my_bus_slave against a queue-based transaction model.
module tb_my_bus_slave;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] mode = '0;
  logic [7:0] addr = '0;
  logic [7:0] data = '0;
  logic       sel = 1'b0;
  logic [7:0] rdata;
  logic       rvalid, busy, err;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  my_bus_slave #(
    .BASE_ADDR(8'h20),
    .DEPTH    (16),
    .RST_VAL  (8'h00)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .mode  (mode),
    .addr  (addr),
    .data  (data),
    .sel   (sel),
    .rdata (rdata),
    .rvalid(rvalid),
    .busy  (busy),
    .err   (err)
  );

  always #5 clk = ~clk;

  // Reference model: register image, queue of pending burst read offsets,
  // write-burst pointer, and the outputs expected after the next edge.
  logic [7:0]  m_mem [16];
  int unsigned rd_q [$];
  bit          wr_on;
  int unsigned wr_ptr;
  bit          e_rvalid, e_busy, e_err;
  logic [7:0]  e_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    rd_q.delete();
    wr_on    = 0;
    wr_ptr   = 0;
    e_rvalid = 0;
    e_busy   = 0;
    e_err    = 0;
    e_rdata  = 8'h00;
  endfunction

  function automatic void model_step(input bit s, input logic [2:0] m,
                                     input logic [7:0] a, input logic [7:0] d);
    bit          was_busy = e_busy;
    bit          hit      = (a / 16) == 2;
    int unsigned off      = a % 16;
    e_rvalid = 0;
    e_busy   = 0;
    e_err    = 0;
    if (rd_q.size() > 0) begin
      e_rdata  = m_mem[rd_q.pop_front()];
      e_rvalid = 1;
      e_busy   = 1;
    end
    if (!s) begin
      wr_on = 0;
      return;
    end
    if (was_busy) begin
      if (m != 3'd0) e_err = 1;
      return;
    end
    if (wr_on && m == 3'd3) begin
      m_mem[wr_ptr] = d;
      wr_ptr = (wr_ptr + 1) % 16;
      return;
    end
    wr_on = 0;
    case (m)
      3'd0: ;
      3'd1: if (hit) m_mem[off] = d; else e_err = 1;
      3'd2: begin
        if (hit) begin
          e_rdata  = m_mem[off];
          e_rvalid = 1;
        end else e_err = 1;
      end
      3'd3: begin
        if (hit) begin
          m_mem[off] = d;
          wr_on  = 1;
          wr_ptr = (off + 1) % 16;
        end else e_err = 1;
      end
      3'd4: begin
        if (hit && d != 0) begin
          for (int i = 0; i < int'(d); i++) rd_q.push_back((off + i) % 16);
          e_rdata  = m_mem[rd_q.pop_front()];
          e_rvalid = 1;
          e_busy   = 1;
        end else e_err = 1;
      end
      default: e_err = 1;
    endcase
  endfunction

  task automatic check_outputs();
    check("rvalid", 32'(rvalid), 32'(e_rvalid));
    check("busy",   32'(busy),   32'(e_busy));
    check("err",    32'(err),    32'(e_err));
    check("rdata",  32'(rdata),  32'(e_rdata));
  endtask

  // Called at a negedge: drive one command, let one posedge pass, check at next negedge.
  task automatic cycle(input bit s, input logic [2:0] m, input logic [7:0] a, input logic [7:0] d);
    sel  = s;
    mode = m;
    addr = a;
    data = d;
    model_step(s, m, a, d);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cycle(0, 3'd0, 8'h00, 8'h00);
  endtask

  initial begin
    model_reset();
    #12;
    check("reset_rdata",  32'(rdata),  32'h0);
    check("reset_rvalid", 32'(rvalid), 32'h0);
    check("reset_busy",   32'(busy),   32'h0);
    check("reset_err",    32'(err),    32'h0);
    @(negedge clk);
    rst = 1'b1;

    cycle(1, 3'd2, 8'h25, 8'h00);
    check("read_after_reset", 32'({rvalid, rdata}), 32'h100);
    cycle(1, 3'd1, 8'h23, 8'hA5);
    cycle(1, 3'd2, 8'h23, 8'h00);
    check("write_then_read", 32'({rvalid, rdata}), 32'h1A5);

    cycle(1, 3'd3, 8'h2E, 8'd11);
    cycle(1, 3'd3, 8'h00, 8'd22);
    cycle(1, 3'd3, 8'h77, 8'd33);
    cycle(1, 3'd3, 8'h2E, 8'd44);
    idle(1);
    cycle(1, 3'd4, 8'h2E, 8'd4);
    check("burst_beat1", 32'({busy, rvalid, rdata}), 32'h30B);
    idle(5);

    cycle(1, 3'd1, 8'h40, 8'h5A);
    cycle(1, 3'd6, 8'h20, 8'h5A);
    cycle(1, 3'd4, 8'h20, 8'h00);
    check("n0_err", 32'({err, rvalid}), 32'h2);
    cycle(1, 3'd2, 8'h20, 8'h00);

    cycle(1, 3'd4, 8'h20, 8'd8);
    idle(2);
    cycle(1, 3'd1, 8'h24, 8'hEE);
    check("write_during_burst_err", 32'({err, busy}), 32'h3);
    idle(7);
    cycle(1, 3'd2, 8'h24, 8'h00);

    cycle(1, 3'd4, 8'h2E, 8'd6);
    idle(1);
    sel = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("rst_rvalid", 32'(rvalid), 32'h0);
    check("rst_busy",   32'(busy),   32'h0);
    check("rst_rdata",  32'(rdata),  32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    idle(2);
    cycle(1, 3'd4, 8'h20, 8'd16);
    idle(17);

    for (int i = 0; i < 1500; i++) begin
      bit         s;
      logic [2:0] m;
      logic [7:0] a, d;
      int unsigned r;
      s = $urandom_range(0, 9) != 0;
      r = $urandom_range(0, 19);
      m = (r < 4) ? 3'd1 : (r < 8) ? 3'd2 : (r < 12) ? 3'd3 : (r < 14) ? 3'd4 :
          (r < 17) ? 3'd0 : 3'($urandom_range(5, 7));
      a = ($urandom_range(0, 9) != 0) ? 8'(8'h20 + $urandom_range(0, 15)) : 8'($urandom);
      d = (m == 3'd4) ? 8'($urandom_range(0, 20)) : 8'($urandom);
      cycle(s, m, a, d);
    end
    idle(25);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
